imem_boot_ctrl: RTL and testbench

//  Boot-time sequencer for the 512-word instruction memory.
//  - Receives a program image as a byte stream (UART-side valid/ready).
//  - Assembles the bytes into little-endian 32-bit words and drives the imem write port.
//  - Holds the core stalled until the image is fully written, then hands imem to CPU fetch.
//  - Sits between the UART receiver, the imem write/read ports and the core's stall input.

---
 rtl/imem_boot_ctrl.sv | 105 ++++++++++
 tb/tb_imem_boot_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_ctrl.sv
// Boot-time loader: assembles a length-prefixed little-endian byte image into imem words,
// holding the core stalled until the whole image has been written.
module imem_boot_ctrl #(
   parameter int DEPTH_WORDS = 512,
   parameter int ADDR_W      = 9
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_rx_valid,
   input  logic [7:0]        i_rx_data,
   output logic              o_rx_ready,
   input  logic [31:0]       i_cpu_addr,
   output logic [ADDR_W-1:0] o_mem_raddr,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_waddr,
   output logic [31:0]       o_mem_wdata,
   output logic              o_cpu_stall,
   output logic              o_done,
   output logic              o_err
);

   typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, FLUSH, DONE, ERR} state_t;

   localparam logic [15:0] MAX_N = 16'(DEPTH_WORDS);

   state_t          state;
   logic [15:0]     len;
   logic [ADDR_W:0] word_cnt;
   logic [1:0]      byte_idx;
   logic [23:0]     wbuf;
   logic            accept;
   logic [15:0]     len_full;
   logic [15:0]     cnt_next;
   logic            unused_addr_bits;

   assign o_rx_ready  = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
   assign accept      = i_rx_valid && o_rx_ready;
   assign o_mem_raddr = i_cpu_addr[ADDR_W+1:2];
   assign len_full    = {i_rx_data, len[7:0]};
   assign cnt_next    = 16'(word_cnt) + 16'd1;
   assign unused_addr_bits = ^{i_cpu_addr[31:ADDR_W+2], i_cpu_addr[1:0]};

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state       <= LEN_LO;
         len         <= '0;
         word_cnt    <= '0;
         byte_idx    <= '0;
         wbuf        <= '0;
         o_mem_we    <= 1'b0;
         o_mem_waddr <= '0;
         o_mem_wdata <= '0;
         o_cpu_stall <= 1'b1;
         o_done      <= 1'b0;
         o_err       <= 1'b0;
      end else begin
         o_mem_we <= 1'b0;
         case (state)
            LEN_LO: begin
               if (accept) begin
                  len[7:0] <= i_rx_data;
                  state    <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (accept) begin
                  len[15:8] <= i_rx_data;
                  if (len_full == 16'd0) begin
                     state <= FLUSH;
                  end else if (len_full > MAX_N) begin
                     state <= ERR;
                     o_err <= 1'b1;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (accept) begin
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     // Lane 3 bypasses the buffer so the write issues on the very next cycle
                     o_mem_we    <= 1'b1;
                     o_mem_waddr <= word_cnt[ADDR_W-1:0];
                     o_mem_wdata <= {i_rx_data, wbuf};
                     word_cnt    <= word_cnt + 1'b1;
                     if (cnt_next == len) state <= FLUSH;
                  end else begin
                     wbuf[{byte_idx, 3'b000} +: 8] <= i_rx_data;
                  end
               end
            end
            FLUSH: begin
               state       <= DONE;
               o_cpu_stall <= 1'b0;
               o_done      <= 1'b1;
            end
            DONE: state <= DONE;
            ERR:  state <= ERR;
            default: state <= ERR;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scoreboard bench for imem_boot_ctrl: expected writes are queued as bytes are driven
// and matched against each o_mem_we pulse.
module tb_imem_boot_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_ready;
   logic [31:0] cpu_addr = '0;
   logic [8:0]  mem_raddr;
   logic        mem_we;
   logic [8:0]  mem_waddr;
   logic [31:0] mem_wdata;
   logic        cpu_stall;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;
   int wr_base;
   logic [8:0] last_waddr = '0;
   logic [40:0] exp_q[$];

   imem_boot_ctrl #(.DEPTH_WORDS(512), .ADDR_W(9)) dut (
      .i_clk(clk), .i_reset(rst), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
      .o_rx_ready(rx_ready), .i_cpu_addr(cpu_addr), .o_mem_raddr(mem_raddr),
      .o_mem_we(mem_we), .o_mem_waddr(mem_waddr), .o_mem_wdata(mem_wdata),
      .o_cpu_stall(cpu_stall), .o_done(done), .o_err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_we) begin
         wr_count++;
         last_waddr = mem_waddr;
         if (exp_q.size() == 0) begin
            check("unexpected_we", 64'(mem_waddr), 64'h1ff_dead);
         end else begin
            logic [40:0] e;
            e = exp_q.pop_front();
            check("waddr", 64'(mem_waddr), 64'(e[40:32]));
            check("wdata", 64'(mem_wdata), 64'(e[31:0]));
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      rx_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      rx_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      rx_valid = 1'b1;
      rx_data  = b;
      n = 0;
      while (!rx_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!rx_ready) check("ready_timeout", 0, 1);
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [8:0] addr, input logic [31:0] w, input int maxgap);
      exp_q.push_back({addr, w});
      for (int unsigned i = 0; i < 4; i++) begin
         logic [31:0] sh;
         sh = w >> (8 * i);
         send_byte(sh[7:0], $urandom_range(0, maxgap));
      end
   endtask

   task automatic wait_end(input int max);
      int n = 0;
      while (!(done || err) && n < max) begin @(posedge clk); #1; n++; end
      if (!(done || err)) check("end_timeout", 0, 1);
   endtask

   initial begin
      logic [31:0] a;
      do_reset();
      check("rst_stall", 64'(cpu_stall), 1);
      check("rst_done",  64'(done), 0);
      check("rst_err",   64'(err), 0);
      check("rst_we",    64'(mem_we), 0);
      check("rst_waddr", 64'(mem_waddr), 0);
      check("rst_wdata", 64'(mem_wdata), 0);
      check("rst_ready", 64'(rx_ready), 1);
      for (int i = 0; i < 3; i++) begin
         a = $urandom();
         cpu_addr = a;
         #1 check("raddr", 64'(mem_raddr), 64'((a >> 2) & 32'h1ff));
      end

      // 1: single word, exact handoff timing
      wr_base = wr_count;
      send_byte(8'h01, 0); send_byte(8'h00, 0);
      exp_q.push_back({9'd0, 32'h0000_0013});
      send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      check("t1_we_cycle", 64'(mem_we), 1);
      check("t1_stall_during_write", 64'(cpu_stall), 1);
      check("t1_ready_flush", 64'(rx_ready), 0);
      @(posedge clk); #1;
      check("t1_stall", 64'(cpu_stall), 0);
      check("t1_done", 64'(done), 1);
      check("t1_we_off", 64'(mem_we), 0);
      check("t1_nwr", 64'(wr_count - wr_base), 1);

      // 2: three words with random rx bubbles
      do_reset();
      wr_base = wr_count;
      send_byte(8'h03, 1); send_byte(8'h00, 2);
      for (int i = 0; i < 3; i++) send_word(9'(i), $urandom(), 3);
      wait_end(20);
      check("t2_done", 64'(done), 1);
      check("t2_err", 64'(err), 0);
      check("t2_nwr", 64'(wr_count - wr_base), 3);
      check("t2_q_empty", 64'(exp_q.size()), 0);

      // 3: empty image
      do_reset();
      wr_base = wr_count;
      send_byte(8'h00, 0); send_byte(8'h00, 0);
      check("t3_flush_ready", 64'(rx_ready), 0);
      check("t3_flush_stall", 64'(cpu_stall), 1);
      check("t3_flush_done", 64'(done), 0);
      @(posedge clk); #1;
      check("t3_done", 64'(done), 1);
      check("t3_stall", 64'(cpu_stall), 0);
      check("t3_nwr", 64'(wr_count - wr_base), 0);

      // 4: oversize image rejected
      do_reset();
      wr_base = wr_count;
      send_byte(8'h01, 0); send_byte(8'h02, 0);
      check("t4_err", 64'(err), 1);
      check("t4_stall", 64'(cpu_stall), 1);
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("t4_ready", 64'(rx_ready), 0);
      end
      rx_valid = 1'b0;
      check("t4_err_sticky", 64'(err), 1);
      check("t4_done", 64'(done), 0);
      check("t4_nwr", 64'(wr_count - wr_base), 0);

      // 5: full-depth image
      do_reset();
      wr_base = wr_count;
      send_byte(8'h00, 0); send_byte(8'h02, 0);
      for (int i = 0; i < 512; i++) send_word(9'(i), $urandom(), 0);
      wait_end(10);
      check("t5_done", 64'(done), 1);
      check("t5_err", 64'(err), 0);
      check("t5_last_waddr", 64'(last_waddr), 511);
      check("t5_nwr", 64'(wr_count - wr_base), 512);

      // 6: reset mid-word, then a fresh single-word image
      do_reset();
      wr_base = wr_count;
      send_byte(8'h01, 0); send_byte(8'h00, 0);
      send_byte(8'hAA, 0); send_byte(8'hBB, 0);
      do_reset();
      check("t6_ready", 64'(rx_ready), 1);
      check("t6_stall", 64'(cpu_stall), 1);
      check("t6_done_clr", 64'(done), 0);
      send_byte(8'h01, 0); send_byte(8'h00, 0);
      send_word(9'd0, 32'h4433_2211, 1);
      wait_end(10);
      check("t6_done", 64'(done), 1);
      check("t6_nwr", 64'(wr_count - wr_base), 1);
      check("t6_q_empty", 64'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
